// File: rtl/spectral_hop_scheduler_if.sv
// spectral_hop_scheduler_if: config, control and shifter-drive signals of the hop scheduler.
// o_hop_count exists only when HOP_COUNT_EN is defined.
interface spectral_hop_scheduler_if #(
    parameter int AW      = 3,
    parameter int DWELL_W = 16
);
    logic               i_cfg_we;
    logic [AW-1:0]      i_cfg_addr;
    logic [31:0]        i_cfg_freq;
    logic [DWELL_W-1:0] i_cfg_dwell;
    logic [AW:0]        i_num_hops;
    logic               i_loop;
    logic               i_start;
    logic               i_stop;
    logic               i_valid;
    logic [31:0]        o_frequency;
    logic               o_switch;
    logic [AW-1:0]      o_hop_idx;
    logic               o_hop_strobe;
    logic               o_busy;
    logic               o_done;
`ifdef HOP_COUNT_EN
    logic [15:0]        o_hop_count;
`endif

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_freq, i_cfg_dwell,
        output i_num_hops, i_loop, i_start, i_stop, i_valid,
`ifdef HOP_COUNT_EN
        input  o_hop_count,
`endif
        input  o_frequency, o_switch, o_hop_idx,
        input  o_hop_strobe, o_busy, o_done
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_freq, i_cfg_dwell,
        input  i_num_hops, i_loop, i_start, i_stop, i_valid,
`ifdef HOP_COUNT_EN
        output o_hop_count,
`endif
        output o_frequency, o_switch, o_hop_idx,
        output o_hop_strobe, o_busy, o_done
    );
endinterface

// File: rtl/spectral_hop_scheduler.sv
// spectral_hop_scheduler: steps an NCO phase-increment table with per-entry dwell and settle.
// Define HOP_COUNT_EN to add o_hop_count (completed dwells, saturating).
module spectral_hop_scheduler #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 4
) (
    input logic i_clk,
    input logic i_rst,
    spectral_hop_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DWELL_W-1:0] SETTLE_M1 =
        (SETTLE > 0) ? DWELL_W'(SETTLE - 1) : '0;
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DWELL} state_t;
    localparam state_t S_FIRST = (SETTLE == 0) ? S_DWELL : S_SETTLE;

    state_t r_state, w_state_nxt;

    logic [31:0]        r_freq_tbl  [DEPTH];
    logic [DWELL_W-1:0] r_dwell_tbl [DEPTH];

    logic [31:0]        r_freq;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [AW-1:0]      r_idx;
    logic [AW:0]        r_num;
    logic               r_loop;
    logic               r_strobe;
    logic               r_done;

    logic               w_start;
    logic               w_load;
    logic [AW-1:0]      w_load_idx;
    logic               w_done;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_dwell_end;
    logic               w_more;
    logic [AW:0]        w_num_clip;
    logic [DWELL_W-1:0] w_dwell_m1;

    assign w_num_clip = (bus.i_num_hops > DEPTH_N) ? DEPTH_N : bus.i_num_hops;
    // A zero dwell is served as a single-sample dwell.
    assign w_dwell_m1 = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
    assign w_more     = {1'b0, r_idx} < (r_num - (AW+1)'(1));

    always_ff @(posedge i_clk) begin
        if (bus.i_cfg_we) begin
            r_freq_tbl[bus.i_cfg_addr]  <= bus.i_cfg_freq;
            r_dwell_tbl[bus.i_cfg_addr] <= bus.i_cfg_dwell;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_done      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_dwell_end = 1'b0;
        if (bus.i_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_start && (w_num_clip != '0)) begin
                        w_start     = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_FIRST;
                    end
                end
                S_SETTLE: begin
                    if (bus.i_valid) begin
                        if (r_cnt == SETTLE_M1) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_DWELL;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_DWELL: begin
                    if (bus.i_valid) begin
                        if (r_cnt == w_dwell_m1) begin
                            w_dwell_end = 1'b1;
                            if (w_more || r_loop) begin
                                w_load      = 1'b1;
                                w_load_idx  = w_more ? r_idx + AW'(1) : '0;
                                w_state_nxt = S_FIRST;
                            end else begin
                                w_done      = 1'b1;
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_freq   <= '0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_num    <= '0;
            r_loop   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_strobe <= w_load;
            r_done   <= w_done;
            if (w_start) begin
                r_num  <= w_num_clip;
                r_loop <= bus.i_loop;
            end
            // The table is read only here, so late rewrites land at the next load.
            if (w_load) begin
                r_idx   <= w_load_idx;
                r_freq  <= r_freq_tbl[w_load_idx];
                r_dwell <= r_dwell_tbl[w_load_idx];
            end
            if (w_load || w_cnt_clr) r_cnt <= '0;
            else if (w_cnt_inc)      r_cnt <= r_cnt + DWELL_W'(1);
        end
    end

`ifdef HOP_COUNT_EN
    logic [15:0] r_hop_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                    r_hop_cnt <= '0;
        else if (w_start)                             r_hop_cnt <= '0;
        else if (w_dwell_end && r_hop_cnt != 16'hFFFF) r_hop_cnt <= r_hop_cnt + 16'd1;
    end

    assign bus.o_hop_count = r_hop_cnt;
`endif

    assign bus.o_frequency  = r_freq;
    assign bus.o_switch     = (r_state == S_DWELL);
    assign bus.o_hop_idx    = r_idx;
    assign bus.o_hop_strobe = r_strobe;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_done       = r_done;
endmodule

// File: tb/tb_spectral_hop_scheduler.sv
// tb_spectral_hop_scheduler: randomized bench for the hop scheduler.
// Hop segments are rebuilt from the output trace and compared with the table rules.
module tb_spectral_hop_scheduler;
    localparam int SET = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spectral_hop_scheduler_if #(.AW(3), .DWELL_W(16)) bus ();

    spectral_hop_scheduler #(.DEPTH(8), .DWELL_W(16), .SETTLE(SET)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int gcyc   = 0;

    logic [31:0] m_freq  [8];
    int          m_dwell [8];

    logic [31:0] q_freq [$];
    int          q_idx  [$];
    int          q_set  [$];
    int          q_dw   [$];
    int          q_cyc  [$];
    bit          q_adj  [$];
    int          n_done;
    bit          done_adj;
    int          n_bad;
    bit          prev_last;
    bit          to;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic clr();
        q_freq.delete(); q_idx.delete(); q_set.delete();
        q_dw.delete(); q_cyc.delete(); q_adj.delete();
        n_done = 0; done_adj = 0; n_bad = 0; prev_last = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] f, input int d);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = 3'(a);
        bus.i_cfg_freq  = f;
        bus.i_cfg_dwell = 16'(d);
        @(posedge clk); #1;
        bus.i_cfg_we = 1'b0;
        m_freq[a]  = f;
        m_dwell[a] = d;
    endtask

    // Trace monitor: one segment per strobe, samples split by o_switch.
    task automatic run(input int max_cyc, input int vmode, input int end_str);
        bit fin;
        fin = 0;
        to  = 0;
        for (int c = 0; c < max_cyc; c++) begin
            case (vmode)
                0:       bus.i_valid = 1'b1;
                1:       bus.i_valid = (gcyc % 3 == 0);
                default: bus.i_valid = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (bus.o_switch && !bus.o_busy) n_bad++;
            if (bus.o_hop_strobe) begin
                if (!bus.o_busy) n_bad++;
                q_freq.push_back(bus.o_frequency);
                q_idx.push_back(int'(bus.o_hop_idx));
                q_set.push_back(0);
                q_dw.push_back(0);
                q_cyc.push_back(c);
                q_adj.push_back(prev_last);
                if (q_freq.size() == end_str) fin = 1;
            end
            if (bus.o_done) begin
                n_done++;
                done_adj = prev_last;
                if (bus.o_busy) n_bad++;
                fin = 1;
            end
            if (bus.i_valid && bus.o_busy && q_set.size() > 0) begin
                if (bus.o_switch) begin
                    q_dw[q_dw.size()-1] += 1;
                end else begin
                    if (q_dw[q_dw.size()-1] != 0) n_bad++;
                    q_set[q_set.size()-1] += 1;
                end
            end
            prev_last = bus.i_valid && bus.o_switch;
            gcyc++;
            @(posedge clk); #1;
            bus.i_start  = 1'b0;
            bus.i_stop   = 1'b0;
            bus.i_cfg_we = 1'b0;
            if (fin) return;
        end
        to = 1;
    endtask

    task automatic test_reset();
        bus.i_cfg_we = 0; bus.i_cfg_addr = 0; bus.i_cfg_freq = 0;
        bus.i_cfg_dwell = 0; bus.i_num_hops = 0; bus.i_loop = 0;
        bus.i_start = 0; bus.i_stop = 0; bus.i_valid = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_frequency !== 32'h0) begin
            errors++;
            $display("FAIL reset_freq got %h exp 0", bus.o_frequency);
        end
        checks++;
        if ({bus.o_switch, bus.o_hop_idx, bus.o_hop_strobe, bus.o_busy, bus.o_done} !== 7'h0) begin
            errors++;
            $display("FAIL reset_flags got sw%b idx%0d st%b bz%b dn%b exp 0",
                bus.o_switch, bus.o_hop_idx, bus.o_hop_strobe, bus.o_busy, bus.o_done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wr(0, 32'h0100_0000, 10);
        bus.i_num_hops = 1; bus.i_loop = 0; bus.i_start = 1;
        clr();
        run(200, 0, 0);
        checks++;
        if (to || q_freq.size() != 1) begin
            errors++;
            $display("FAIL single_hops got %0d to%0b exp 1", q_freq.size(), to);
        end else begin
            checks++;
            if (q_cyc[0] != 1) begin
                errors++; $display("FAIL single_latency got %0d exp 1", q_cyc[0]);
            end
            checks++;
            if (q_freq[0] !== 32'h0100_0000) begin
                errors++; $display("FAIL single_freq got %h exp 01000000", q_freq[0]);
            end
            checks++;
            if (q_set[0] != SET || q_dw[0] != 10) begin
                errors++;
                $display("FAIL single_samples got %0d/%0d exp %0d/10", q_set[0], q_dw[0], SET);
            end
        end
        checks++;
        if (n_done != 1 || !done_adj) begin
            errors++; $display("FAIL single_done got %0d adj%0b exp 1 adj1", n_done, done_adj);
        end
        @(negedge clk);
        checks++;
        if (bus.o_busy || bus.o_switch || bus.o_done) begin
            errors++;
            $display("FAIL single_idle got bz%b sw%b dn%b exp 000", bus.o_busy, bus.o_switch, bus.o_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_three_hops();
        int gap;
        wr(0, 32'h1000, 2);
        wr(1, 32'h2000, 3);
        wr(2, 32'h3000, 5);
        bus.i_num_hops = 3; bus.i_loop = 0; bus.i_start = 1;
        clr();
        run(600, 1, 0);
        checks++;
        if (to || q_freq.size() != 3 || n_done != 1) begin
            errors++;
            $display("FAIL three_count got %0d done%0d to%0b exp 3 done1", q_freq.size(), n_done, to);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (q_freq[k] !== m_freq[k] || q_idx[k] != k) begin
                    errors++;
                    $display("FAIL three_freq%0d got %h/%0d exp %h/%0d", k, q_freq[k], q_idx[k], m_freq[k], k);
                end
                checks++;
                if (q_set[k] != SET || q_dw[k] != eff(m_dwell[k])) begin
                    errors++;
                    $display("FAIL three_samp%0d got %0d/%0d exp %0d/%0d", k, q_set[k], q_dw[k], SET, eff(m_dwell[k]));
                end
            end
            gap = q_cyc[1] - q_cyc[0];
            checks++;
            if (gap < 3*(SET+2)-2 || gap > 3*(SET+2)) begin
                errors++; $display("FAIL three_gap0 got %0d exp %0d..%0d", gap, 3*(SET+2)-2, 3*(SET+2));
            end
            gap = q_cyc[2] - q_cyc[1];
            checks++;
            if (gap != 3*(SET+3)) begin
                errors++; $display("FAIL three_gap1 got %0d exp %0d", gap, 3*(SET+3));
            end
        end
    endtask

    task automatic test_loop_stop();
        bit seen;
        int dn;
        wr(0, 32'hA0, 3);
        wr(1, 32'hB0, 6);
        bus.i_num_hops = 2; bus.i_loop = 1; bus.i_start = 1;
        clr();
        run(800, 2, 6);
        checks++;
        if (to || q_freq.size() != 6 || n_done != 0) begin
            errors++;
            $display("FAIL loop_count got %0d done%0d to%0b exp 6 done0", q_freq.size(), n_done, to);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (q_idx[k] != k % 2 || q_freq[k] !== m_freq[k % 2]) begin
                    errors++;
                    $display("FAIL loop_idx%0d got %0d/%h exp %0d/%h", k, q_idx[k], q_freq[k], k % 2, m_freq[k % 2]);
                end
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (q_set[k] != SET || q_dw[k] != eff(m_dwell[k % 2]) || (k > 0 && !q_adj[k])) begin
                    errors++;
                    $display("FAIL loop_samp%0d got %0d/%0d adj%0b exp %0d/%0d", k, q_set[k], q_dw[k], q_adj[k], SET, eff(m_dwell[k % 2]));
                end
            end
        end
        seen = 0;
        bus.i_valid = 1'b1;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_switch) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL loop_reach_dwell got 0 exp 1");
        end
        bus.i_valid = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_hop_strobe || !bus.o_switch || bus.o_hop_idx !== 3'd1) begin
            errors++;
            $display("FAIL busy_start got st%b sw%b idx%0d exp st0 sw1 idx1", bus.o_hop_strobe, bus.o_switch, bus.o_hop_idx);
        end
        bus.i_stop = 1'b1;
        @(posedge clk); #1;
        bus.i_stop = 1'b0;
        bus.i_valid = 1'b1;
        dn = 0;
        @(negedge clk);
        checks++;
        if (bus.o_switch || bus.o_busy || bus.o_frequency !== 32'hB0) begin
            errors++;
            $display("FAIL stop_state got sw%b bz%b f%h exp sw0 bz0 fB0", bus.o_switch, bus.o_busy, bus.o_frequency);
        end
        for (int c = 0; c < 6; c++) begin
            if (bus.o_done) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0) begin
            errors++; $display("FAIL stop_done got %0d exp 0", dn);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_edges();
        int nb;
        wr(0, 32'h55, 0);
        bus.i_num_hops = 1; bus.i_loop = 0; bus.i_start = 1;
        clr();
        run(100, 0, 0);
        checks++;
        if (to || q_dw.size() != 1 || n_done != 1) begin
            errors++; $display("FAIL dwell0_run got %0d done%0d exp 1 done1", q_dw.size(), n_done);
        end else begin
            checks++;
            if (q_dw[0] != 1) begin
                errors++; $display("FAIL dwell0_len got %0d exp 1", q_dw[0]);
            end
        end
        bus.i_num_hops = 0; bus.i_start = 1;
        nb = 0;
        @(posedge clk); #1;
        bus.i_start = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_hop_strobe) nb++;
        end
        checks++;
        if (nb != 0) begin
            errors++; $display("FAIL num0 got %0d busy cycles exp 0", nb);
        end
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) wr(a, 32'h100 + 32'(a), a % 3);
        bus.i_num_hops = 12; bus.i_start = 1;
        clr();
        run(2000, 2, 0);
        checks++;
        if (to || q_idx.size() != 8 || n_done != 1) begin
            errors++;
            $display("FAIL clip_count got %0d done%0d to%0b exp 8 done1", q_idx.size(), n_done, to);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (q_idx[k] != k || q_freq[k] !== m_freq[k] || q_dw[k] != eff(m_dwell[k])) begin
                    errors++;
                    $display("FAIL clip_hop%0d got %0d/%h/%0d exp %0d/%h/%0d", k, q_idx[k], q_freq[k], q_dw[k], k, m_freq[k], eff(m_dwell[k]));
                end
            end
        end
        bus.i_num_hops = 1; bus.i_start = 1; bus.i_stop = 1;
        @(posedge clk); #1;
        bus.i_start = 0; bus.i_stop = 0;
        @(negedge clk);
        checks++;
        if (bus.o_busy || bus.o_hop_strobe) begin
            errors++;
            $display("FAIL start_stop got bz%b st%b exp 00", bus.o_busy, bus.o_hop_strobe);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_reset();
        bit seen;
        wr(0, 32'h10, 20);
        wr(1, 32'h1111, 3);
        bus.i_num_hops = 2; bus.i_loop = 0; bus.i_start = 1;
        clr();
        run(100, 0, 1);
        seen = 0;
        bus.i_valid = 1'b1;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_switch) seen = 1;
            else begin @(posedge clk); #1; end
        end
        bus.i_valid = 1'b0;
        wr(1, 32'hABCD, 3);
        run(200, 0, 0);
        checks++;
        if (!seen || to || q_freq.size() != 2) begin
            errors++; $display("FAIL wr_run got %0d seen%0b exp 2 seen1", q_freq.size(), seen);
        end else begin
            checks++;
            if (q_freq[1] !== 32'hABCD || q_idx[1] != 1) begin
                errors++; $display("FAIL wr_load got %h/%0d exp 0000abcd/1", q_freq[1], q_idx[1]);
            end
        end
        bus.i_num_hops = 2; bus.i_loop = 1; bus.i_start = 1;
        clr();
        run(100, 0, 2);
        @(negedge clk);
        checks++;
        if (!bus.o_busy || bus.o_switch || bus.o_hop_idx !== 3'd1) begin
            errors++;
            $display("FAIL pre_rst got bz%b sw%b idx%0d exp bz1 sw0 idx1", bus.o_busy, bus.o_switch, bus.o_hop_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_frequency, bus.o_switch, bus.o_hop_idx, bus.o_hop_strobe, bus.o_busy, bus.o_done} !== 39'h0) begin
            errors++;
            $display("FAIL rst_settle got f%h sw%b idx%0d bz%b exp 0", bus.o_frequency, bus.o_switch, bus.o_hop_idx, bus.o_busy);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1;
        clr();
        run(100, 0, 1);
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_switch) seen = 1;
            else begin @(posedge clk); #1; end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!seen || bus.o_switch || bus.o_busy || bus.o_frequency !== 32'h0) begin
            errors++;
            $display("FAIL rst_dwell got seen%0b sw%b bz%b f%h exp seen1 sw0 bz0 f0", seen, bus.o_switch, bus.o_busy, bus.o_frequency);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 8; a++) wr(a, $urandom, $urandom_range(0, 5));
            n = $urandom_range(1, 8);
            bus.i_num_hops = 4'(n); bus.i_loop = 0; bus.i_start = 1;
            clr();
            run(3000, 2, 0);
            checks++;
            if (to || q_freq.size() != n || n_done != 1 || !done_adj || n_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_run got %0d done%0d adj%0b bad%0d exp %0d done1 adj1 bad0", it, q_freq.size(), n_done, done_adj, n_bad, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (q_freq[k] !== m_freq[k] || q_idx[k] != k || q_set[k] != SET || q_dw[k] != eff(m_dwell[k]) || (k > 0 && !q_adj[k])) begin
                        errors++;
                        $display("FAIL rand%0d_hop%0d got %h/%0d/%0d/%0d adj%0b exp %h/%0d/%0d/%0d", it, k, q_freq[k], q_idx[k], q_set[k], q_dw[k], q_adj[k], m_freq[k], k, SET, eff(m_dwell[k]));
                    end
                end
            end
        end
    endtask

`ifdef HOP_COUNT_EN
    task automatic test_hop_count();
        for (int a = 0; a < 3; a++) wr(a, 32'h700 + 32'(a), 2);
        bus.i_num_hops = 3; bus.i_loop = 1; bus.i_start = 1;
        clr();
        run(500, 0, 8);
        @(negedge clk);
        checks++;
        if (to || bus.o_hop_count !== 16'd7) begin
            errors++; $display("FAIL hop_count got %0d exp 7", bus.o_hop_count);
        end
        @(posedge clk); #1;
        bus.i_stop = 1;
        @(posedge clk); #1;
        bus.i_stop = 0; bus.i_start = 1;
        @(posedge clk); #1;
        bus.i_start = 0;
        @(negedge clk);
        checks++;
        if (bus.o_hop_count !== 16'd0 || !bus.o_hop_strobe) begin
            errors++; $display("FAIL hop_count_clr got %0d st%b exp 0 st1", bus.o_hop_count, bus.o_hop_strobe);
        end
        @(posedge clk); #1;
        bus.i_stop = 1;
        @(posedge clk); #1;
        bus.i_stop = 0;
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_three_hops();
        test_loop_stop();
        test_edges();
        test_write_reset();
        test_random();
`ifdef HOP_COUNT_EN
        test_hop_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
